mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single off-chip memory port between the icache and the future dcache/store path.
//  Picks one requester per cycle and forwards its command to memory.
//  Records which requester owns each outstanding memory tag.
//  Steers each returning tag/data to that owner. Sits between the core's cache controllers and the memory model.
// PARAMETERS
//  XLEN          32  address width
//  NUM_TAGS      16  memory tag space; tag 0 means "none"
//  STARVE_LIMIT  4   consecutive icache losses before icache is forced to win
// PORTS
//  clock               in   1          single clock, rising edge
//  reset               in   1          asynchronous, active-low
//  Icache2mem_command  in   2          BUS_NONE/BUS_LOAD (icache never stores)
//  Icache2mem_addr     in   XLEN       icache request address
//  Dcache2mem_command  in   2          BUS_NONE/BUS_LOAD/BUS_STORE
//  Dcache2mem_addr     in   XLEN       dcache request address
//  Dcache2mem_data     in   64         store data
//  mem2proc_response   in   4          accept tag from memory; 0 = rejected
//  mem2proc_data       in   64         returning load data
//  mem2proc_tag        in   4          completion tag; 0 = none
//  proc2mem_command    out  2          granted command
//  proc2mem_addr       out  XLEN       granted address
//  proc2mem_data       out  64         Dcache2mem_data when dcache granted, else 0
//  mem2Icache_response out  4          mem2proc_response if icache granted, else 0
//  mem2Icache_data     out  64         mem2proc_data (broadcast)
//  mem2Icache_tag      out  4          mem2proc_tag if owner==icache, else 0
//  mem2Dcache_response out  4          mem2proc_response if dcache granted, else 0
//  mem2Dcache_data     out  64         mem2proc_data (broadcast)
//  mem2Dcache_tag      out  4          mem2proc_tag if owner==dcache, else 0
//  outstanding_cnt     out  clog2(NUM_TAGS)+1  number of valid owner entries
//  tag_error           out  1          sticky: completion tag had no valid owner
// BEHAVIOUR
//  - Grant logic is combinational (0-cycle request path). Only registered state: owner table, starve_cnt, tag_error.
//  - Grant rules:
//    - Only one requester has command != BUS_NONE -> that requester wins.
//    - Both request -> dcache wins, unless starve_cnt == STARVE_LIMIT, then icache wins.
//    - Neither requests -> proc2mem_command = BUS_NONE, addr/data = 0.
//  - starve_cnt:
//    - Cleared when icache is granted AND mem2proc_response != 0.
//    - Otherwise increments (saturating at STARVE_LIMIT) each cycle the icache requests and does not get an accepted grant.
//    - Unchanged when the icache is idle.
//  - Memory rejection (response == 0): the granted requester sees 0 and retries. No state changes except starve_cnt.
//  - Allocate: an accepted BUS_LOAD sets owner_valid[resp] = 1 and owner[resp] = winner. An accepted BUS_STORE allocates nothing.
//  - Complete: when mem2proc_tag != 0 and owner_valid[tag] = 1, the tag is routed to its owner and owner_valid[tag] is cleared.
//    The other requester's tag output is 0.
//  - Same tag allocated and completed in the same cycle: clear first, then allocate. The entry ends valid with the new owner.
//  - Completion tag with no valid owner: dropped (both tag outputs 0) and tag_error is set until reset.
//  - Allocating a tag whose entry is already valid overwrites it and also sets tag_error.
//  - outstanding_cnt is the registered popcount of owner_valid.
//  - Reset (asserted asynchronously, at any time, including mid-transaction):
//    - Clears owner_valid, owner, starve_cnt and tag_error.
//    - All outputs are combinational functions of that state and the inputs; with idle inputs they read 0.
//    - Tags returning after reset for pre-reset loads are dropped and flagged.
// STRUCTURE
//  - Shared package: BUS_NONE/BUS_LOAD/BUS_STORE encodings and typedef enum logic {OWNER_ICACHE, OWNER_DCACHE} MEM_OWNER.
//  - Sub-module mem_tag_tracker: NUM_TAGS-entry owner table.
//    - Ports: alloc_en/alloc_tag/alloc_owner, cmpl_tag, lookup owner/valid, count, error.
//    - The top level keeps grant logic and starve_cnt.
// TESTING
//  1. Icache BUS_LOAD 0x100 alone, resp=3; 5 cycles later tag=3, data=0xAB
//     -> mem2Icache_response=3, then mem2Icache_tag=3, data 0xAB, mem2Dcache_tag=0, outstanding 1->0.
//  2. Both load every cycle, memory always accepts
//     -> dcache wins 4 cycles, icache wins the 5th, pattern repeats. Icache never loses more than 4 in a row.
//  3. Dcache BUS_STORE 0x200 data 0x55, resp=7
//     -> proc2mem_data=0x55, outstanding_cnt stays 0. Later tag=7 -> dropped, tag_error=1.
//  4. Tag 2 completes for icache while a dcache load is accepted with resp=2 in the same cycle
//     -> mem2Icache_tag=2, entry 2 now owned by dcache; next tag=2 goes to mem2Dcache_tag.
//  5. Icache load accepted resp=4, reset pulsed low for 1 cycle, then tag=4 returns
//     -> outstanding 0 after reset, both tag outputs 0, tag_error=1.
//  6. Memory rejects (resp=0) for 3 cycles while icache requests
//     -> mem2Icache_response=0 each cycle, starve_cnt not cleared; accepted on 4th cycle -> starve_cnt=0.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Purpose : shared bus command encodings and owner type for the memory-port arbiter.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package mem_bus_arbiter_pkg;

  localparam int XLEN_DEF         = 32;
  localparam int NUM_TAGS_DEF     = 16;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic {
    OWNER_ICACHE = 1'b0,
    OWNER_DCACHE = 1'b1
  } MEM_OWNER;

endpackage

// File: rtl/mem_tag_tracker.sv
// Purpose : NUM_TAGS-entry table recording which requester owns each outstanding memory tag.
// Latency : lookup is combinational on cmpl_tag; table/count/error update on the next clock edge.
// Backpressure: none; every alloc/complete presented is applied in the same cycle.
//
// Ports:
//   clock, reset          clock and async active-low reset
//   alloc_en/tag/owner    record a newly accepted load
//   cmpl_tag              returning tag (0 = none)
//   lookup_valid/owner    owner of cmpl_tag as currently stored
//   count                 registered number of valid entries
//   error                 sticky: completion without owner, or alloc over a live entry
module mem_tag_tracker
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = NUM_TAGS_DEF,
  parameter int TAG_W    = $clog2(NUM_TAGS),
  parameter int CNT_W    = $clog2(NUM_TAGS) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic             alloc_owner,
  input  logic [TAG_W-1:0] cmpl_tag,
  output logic             lookup_valid,
  output logic             lookup_owner,
  output logic [CNT_W-1:0] count,
  output logic             error
);

  logic [NUM_TAGS-1:0] owner_valid_q, owner_valid_d;
  logic [NUM_TAGS-1:0] owner_q, owner_d;   // 1 = dcache, 0 = icache
  logic [CNT_W-1:0]    count_q, count_d;
  logic                error_q, error_d;

  always_comb begin
    lookup_valid = (cmpl_tag != '0) && owner_valid_q[cmpl_tag];
    lookup_owner = owner_q[cmpl_tag];
  end

  always_comb begin
    owner_valid_d = owner_valid_q;
    owner_d       = owner_q;
    error_d       = error_q;

    // Completion is applied before allocation so a tag recycled in the
    // same cycle ends up valid under its new owner without an error.
    if (cmpl_tag != '0) begin
      if (owner_valid_q[cmpl_tag]) begin
        owner_valid_d[cmpl_tag] = 1'b0;
      end else begin
        error_d = 1'b1;
      end
    end

    if (alloc_en) begin
      if (owner_valid_d[alloc_tag]) begin
        error_d = 1'b1;
      end
      owner_valid_d[alloc_tag] = 1'b1;
      owner_d[alloc_tag]       = alloc_owner;
    end

    count_d = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      count_d = count_d + CNT_W'(owner_valid_d[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_valid_q <= '0;
      owner_q       <= '0;
      count_q       <= '0;
      error_q       <= 1'b0;
    end else begin
      owner_valid_q <= owner_valid_d;
      owner_q       <= owner_d;
      count_q       <= count_d;
      error_q       <= error_d;
    end
  end

  assign count = count_q;
  assign error = error_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Purpose : shares the single memory port between icache and dcache and steers returning tags to their owner.
// Latency : 0 cycles request->memory and tag->owner (combinational); owner table/starve state update at clock edge.
// Backpressure: memory rejects with response 0; the granted requester sees 0 and must retry next cycle.
//
// Ports:
//   clock, reset                         clock and async active-low reset
//   Icache2mem_*, Dcache2mem_*           requests from the two cache controllers
//   mem2proc_response/data/tag           accept tag, return data, completion tag from memory
//   proc2mem_command/addr/data           granted request toward memory
//   mem2Icache_*, mem2Dcache_*           per-requester view of the memory responses
//   outstanding_cnt                      number of loads awaiting completion
//   tag_error                            sticky protocol error flag
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int NUM_TAGS     = NUM_TAGS_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TAG_W        = $clog2(NUM_TAGS),
  parameter int CNT_W        = $clog2(NUM_TAGS) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       Icache2mem_command,
  input  logic [XLEN-1:0]  Icache2mem_addr,
  input  logic [1:0]       Dcache2mem_command,
  input  logic [XLEN-1:0]  Dcache2mem_addr,
  input  logic [63:0]      Dcache2mem_data,
  input  logic [TAG_W-1:0] mem2proc_response,
  input  logic [63:0]      mem2proc_data,
  input  logic [TAG_W-1:0] mem2proc_tag,
  output logic [1:0]       proc2mem_command,
  output logic [XLEN-1:0]  proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  output logic [TAG_W-1:0] mem2Icache_response,
  output logic [63:0]      mem2Icache_data,
  output logic [TAG_W-1:0] mem2Icache_tag,
  output logic [TAG_W-1:0] mem2Dcache_response,
  output logic [63:0]      mem2Dcache_data,
  output logic [TAG_W-1:0] mem2Dcache_tag,
  output logic [CNT_W-1:0] outstanding_cnt,
  output logic             tag_error
);

  localparam int ST_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [ST_W-1:0] STARVE_MAX = ST_W'(STARVE_LIMIT);

  logic [ST_W-1:0] starve_cnt_q, starve_cnt_d;

  logic icache_req, dcache_req;
  logic grant_icache, grant_dcache;
  logic accepted;
  logic alloc_en;
  logic lookup_valid, lookup_owner;

  // Dcache normally has priority; once the icache has lost STARVE_LIMIT
  // times in a row it takes the port regardless.
  always_comb begin
    icache_req   = (Icache2mem_command != BUS_NONE);
    dcache_req   = (Dcache2mem_command != BUS_NONE);
    grant_icache = icache_req && (!dcache_req || (starve_cnt_q == STARVE_MAX));
    grant_dcache = dcache_req && !grant_icache;
    accepted     = (mem2proc_response != '0);
  end

  always_comb begin
    proc2mem_command    = BUS_NONE;
    proc2mem_addr       = '0;
    proc2mem_data       = '0;
    mem2Icache_response = '0;
    mem2Dcache_response = '0;
    if (grant_icache) begin
      proc2mem_command    = Icache2mem_command;
      proc2mem_addr       = Icache2mem_addr;
      mem2Icache_response = mem2proc_response;
    end else if (grant_dcache) begin
      proc2mem_command    = Dcache2mem_command;
      proc2mem_addr       = Dcache2mem_addr;
      proc2mem_data       = Dcache2mem_data;
      mem2Dcache_response = mem2proc_response;
    end
  end

  // Stores complete without a tag return, so only loads take a table entry.
  assign alloc_en = accepted && (proc2mem_command == BUS_LOAD);

  always_comb begin
    mem2Icache_data = mem2proc_data;
    mem2Dcache_data = mem2proc_data;
    mem2Icache_tag  = '0;
    mem2Dcache_tag  = '0;
    if (lookup_valid) begin
      if (lookup_owner == OWNER_DCACHE) begin
        mem2Dcache_tag = mem2proc_tag;
      end else begin
        mem2Icache_tag = mem2proc_tag;
      end
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_icache && accepted) begin
      starve_cnt_d = '0;
    end else if (icache_req && (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  mem_tag_tracker #(
    .NUM_TAGS (NUM_TAGS),
    .TAG_W    (TAG_W),
    .CNT_W    (CNT_W)
  ) u_tag_tracker (
    .clock        (clock),
    .reset        (reset),
    .alloc_en     (alloc_en),
    .alloc_tag    (mem2proc_response),
    .alloc_owner  (grant_dcache),
    .cmpl_tag     (mem2proc_tag),
    .lookup_valid (lookup_valid),
    .lookup_owner (lookup_owner),
    .count        (outstanding_cnt),
    .error        (tag_error)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose : randomized + directed bench for mem_bus_arbiter with a queue-based scoreboard.
// Latency : expectations are pushed when inputs are applied and checked on the following falling edge.
// Backpressure: memory acceptance/rejection is driven by the bench's own memory model.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic        clock;
  logic        reset;
  logic [1:0]  ic_cmd, dc_cmd;
  logic [31:0] ic_addr, dc_addr;
  logic [63:0] dc_data;
  logic [3:0]  m_resp, m_tag;
  logic [63:0] m_data;
  logic [1:0]  p_cmd;
  logic [31:0] p_addr;
  logic [63:0] p_data;
  logic [3:0]  i_resp, i_tag, d_resp, d_tag;
  logic [63:0] i_data, d_data;
  logic [4:0]  out_cnt;
  logic        t_err;

  mem_bus_arbiter dut (
    .clock               (clock),
    .reset               (reset),
    .Icache2mem_command  (ic_cmd),
    .Icache2mem_addr     (ic_addr),
    .Dcache2mem_command  (dc_cmd),
    .Dcache2mem_addr     (dc_addr),
    .Dcache2mem_data     (dc_data),
    .mem2proc_response   (m_resp),
    .mem2proc_data       (m_data),
    .mem2proc_tag        (m_tag),
    .proc2mem_command    (p_cmd),
    .proc2mem_addr       (p_addr),
    .proc2mem_data       (p_data),
    .mem2Icache_response (i_resp),
    .mem2Icache_data     (i_data),
    .mem2Icache_tag      (i_tag),
    .mem2Dcache_response (d_resp),
    .mem2Dcache_data     (d_data),
    .mem2Dcache_tag      (d_tag),
    .outstanding_cnt     (out_cnt),
    .tag_error           (t_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] pdata;
    logic [3:0]  ic_resp, dc_resp, ic_tag, dc_tag;
    logic [63:0] rdata;
    logic [4:0]  cnt;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference model: which tags are outstanding and who owns them
  // (1 = icache, 2 = dcache), consecutive icache losses, sticky error.
  bit m_valid[16];
  int m_owner[16];
  int m_starve;
  bit m_error;

  function automatic void model_clear();
    for (int t = 0; t < 16; t++) begin
      m_valid[t] = 1'b0;
      m_owner[t] = 0;
    end
    m_starve = 0;
    m_error  = 1'b0;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int t = 0; t < 16; t++) if (m_valid[t]) c++;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, want);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("proc2mem_command",    64'(p_cmd),   64'(e.cmd));
      chk("proc2mem_addr",       64'(p_addr),  64'(e.addr));
      chk("proc2mem_data",       p_data,       e.pdata);
      chk("mem2Icache_response", 64'(i_resp),  64'(e.ic_resp));
      chk("mem2Dcache_response", 64'(d_resp),  64'(e.dc_resp));
      chk("mem2Icache_tag",      64'(i_tag),   64'(e.ic_tag));
      chk("mem2Dcache_tag",      64'(d_tag),   64'(e.dc_tag));
      chk("mem2Icache_data",     i_data,       e.rdata);
      chk("mem2Dcache_data",     d_data,       e.rdata);
      chk("outstanding_cnt",     64'(out_cnt), 64'(e.cnt));
      chk("tag_error",           64'(t_err),   64'(e.err));
    end
  end

  // Apply one cycle of inputs, push the expected outputs, then advance the model.
  task automatic drive(input logic [1:0] icc, input logic [31:0] ica,
                       input logic [1:0] dcc, input logic [31:0] dca, input logic [63:0] dcd,
                       input logic [3:0] rsp, input logic [3:0] tg, input logic [63:0] dt);
    exp_t e;
    int   win;
    ic_cmd = icc; ic_addr = ica; dc_cmd = dcc; dc_addr = dca; dc_data = dcd;
    m_resp = rsp; m_tag = tg; m_data = dt;

    if (icc != BUS_NONE && (dcc == BUS_NONE || m_starve == 4)) win = 1;
    else if (dcc != BUS_NONE)                                   win = 2;
    else                                                        win = 0;

    e.cmd     = (win == 1) ? icc : (win == 2) ? dcc : BUS_NONE;
    e.addr    = (win == 1) ? ica : (win == 2) ? dca : 32'h0;
    e.pdata   = (win == 2) ? dcd : 64'h0;
    e.ic_resp = (win == 1) ? rsp : 4'h0;
    e.dc_resp = (win == 2) ? rsp : 4'h0;
    e.ic_tag  = (tg != 0 && m_valid[tg] && m_owner[tg] == 1) ? tg : 4'h0;
    e.dc_tag  = (tg != 0 && m_valid[tg] && m_owner[tg] == 2) ? tg : 4'h0;
    e.rdata   = dt;
    e.cnt     = 5'(model_count());
    e.err     = m_error;
    exp_q.push_back(e);

    @(posedge clock);
    #1;
    if (tg != 0) begin
      if (m_valid[tg]) m_valid[tg] = 1'b0;
      else             m_error     = 1'b1;
    end
    if (rsp != 0 && win != 0 && e.cmd == BUS_LOAD) begin
      if (m_valid[rsp]) m_error = 1'b1;
      m_valid[rsp] = 1'b1;
      m_owner[rsp] = win;
    end
    if (win == 1 && rsp != 0)                      m_starve = 0;
    else if (icc != BUS_NONE && m_starve < 4)      m_starve = m_starve + 1;
  endtask

  task automatic idle(input logic [3:0] tg, input logic [63:0] dt);
    drive(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'h0, tg, dt);
  endtask

  // One-cycle reset pulse, asserted between clock edges; outputs must read 0 while held.
  task automatic do_reset();
    exp_t e;
    reset  = 1'b0;
    ic_cmd = BUS_NONE; ic_addr = '0; dc_cmd = BUS_NONE; dc_addr = '0; dc_data = '0;
    m_resp = '0; m_tag = '0; m_data = '0;
    model_clear();
    e.cmd = BUS_NONE; e.addr = '0; e.pdata = '0; e.ic_resp = '0; e.dc_resp = '0;
    e.ic_tag = '0; e.dc_tag = '0; e.rdata = '0; e.cnt = '0; e.err = 1'b0;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset  = 1'b0;
    ic_cmd = BUS_NONE; ic_addr = '0; dc_cmd = BUS_NONE; dc_addr = '0; dc_data = '0;
    m_resp = '0; m_tag = '0; m_data = '0;
    model_clear();
    @(posedge clock);
    #1;
    do_reset();

    // Icache load alone, tag returns five cycles later.
    drive(BUS_LOAD, 32'h100, BUS_NONE, 32'h0, 64'h0, 4'd3, 4'd0, 64'h0);
    repeat (4) idle(4'd0, 64'h0);
    idle(4'd3, 64'hAB);
    idle(4'd0, 64'h0);

    // Both load every cycle: dcache x4 then icache, repeating.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(BUS_LOAD, 32'h1000 + 32'(i), BUS_LOAD, 32'h2000 + 32'(i), 64'h0,
            4'((i % 15) + 1), (i == 0) ? 4'd0 : 4'(((i - 1) % 15) + 1), 64'(i));
    end
    idle(4'(((19) % 15) + 1), 64'h0);
    idle(4'd0, 64'h0);

    // Store allocates nothing; its stray tag is flagged.
    do_reset();
    drive(BUS_NONE, 32'h0, BUS_STORE, 32'h200, 64'h55, 4'd7, 4'd0, 64'h0);
    idle(4'd0, 64'h0);
    idle(4'd7, 64'h77);
    idle(4'd0, 64'h0);

    // Tag 2 completes for icache while being reallocated to dcache.
    do_reset();
    drive(BUS_LOAD, 32'h300, BUS_NONE, 32'h0, 64'h0, 4'd2, 4'd0, 64'h0);
    idle(4'd0, 64'h0);
    drive(BUS_NONE, 32'h0, BUS_LOAD, 32'h400, 64'h0, 4'd2, 4'd2, 64'h11);
    idle(4'd0, 64'h0);
    idle(4'd2, 64'h22);
    idle(4'd0, 64'h0);

    // Reset mid-transaction: returning pre-reset tag is dropped and flagged.
    do_reset();
    drive(BUS_LOAD, 32'h500, BUS_NONE, 32'h0, 64'h0, 4'd4, 4'd0, 64'h0);
    idle(4'd0, 64'h0);
    do_reset();
    idle(4'd4, 64'h44);
    idle(4'd0, 64'h0);

    // Rejections keep counting icache losses; acceptance clears them.
    do_reset();
    repeat (3) drive(BUS_LOAD, 32'h600, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    drive(BUS_LOAD, 32'h600, BUS_NONE, 32'h0, 64'h0, 4'd5, 4'd0, 64'h0);
    for (int k = 0; k < 5; k++) begin
      drive(BUS_LOAD, 32'h700, BUS_LOAD, 32'h800, 64'h0, 4'(8 + k), 4'd0, 64'h0);
    end
    do_reset();
    repeat (3) drive(BUS_LOAD, 32'h600, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    drive(BUS_LOAD, 32'h700, BUS_LOAD, 32'h800, 64'h0, 4'd1, 4'd0, 64'h0);
    drive(BUS_LOAD, 32'h700, BUS_LOAD, 32'h800, 64'h0, 4'd2, 4'd0, 64'h0);
    idle(4'd0, 64'h0);

    // Random traffic against a well-behaved memory, with rare stray tags late on.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      int          fr[$];
      int          vl[$];
      logic [1:0]  icc, dcc;
      logic [3:0]  rsp, tg;
      int          r;
      for (int t = 1; t < 16; t++) begin
        if (!m_valid[t]) fr.push_back(t);
        else             vl.push_back(t);
      end
      icc = ($urandom_range(0, 2) != 0) ? BUS_LOAD : BUS_NONE;
      r   = $urandom_range(0, 3);
      dcc = (r == 0) ? BUS_NONE : (r == 3) ? BUS_STORE : BUS_LOAD;
      rsp = (fr.size() > 0 && $urandom_range(0, 3) != 0) ? 4'(fr[$urandom_range(0, fr.size() - 1)]) : 4'd0;
      tg  = (vl.size() > 0 && $urandom_range(0, 1) != 0) ? 4'(vl[$urandom_range(0, vl.size() - 1)]) : 4'd0;
      if (c > 450 && $urandom_range(0, 63) == 0) tg = 4'($urandom_range(1, 15));
      drive(icc, $urandom(), dcc, $urandom(), {$urandom(), $urandom()}, rsp, tg, {$urandom(), $urandom()});
    end
    idle(4'd0, 64'h0);

    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
